asym_stream_fifo: RTL and testbench

- Single-clock, width-converting FIFO: accepts wide stream words of RATIO packed lanes and emits them as narrow words, lane 0 first, with valid/ready handshakes on both sides.
- Successor to the sliding-window unit's asymmetric RAM:
  - adds occupancy tracking, flow control, a tlast sideband and a synchronous flush;
  - retains the wide-write / narrow-read synchronous memory as its storage core.

---
 rtl/asym_fifo_pkg.sv | 32 +++
 rtl/asym_ram_wide_wr.sv | 48 ++++
 rtl/asym_stream_fifo.sv | 121 ++++++++++++
 tb/tb_asym_stream_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asym_fifo_pkg.sv
// Shared sizing helpers for the width-converting stream FIFO and its storage core.
package asym_fifo_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic int lane_width(input int ratio);
    return clog2(ratio);
  endfunction

  function automatic int wr_width(input int rd_width, input int ratio);
    return rd_width * ratio;
  endfunction

  function automatic int rd_depth(input int wr_depth, input int ratio);
    return wr_depth * ratio;
  endfunction

  // One extra bit beyond what RD_DEPTH needs keeps the free-space subtraction unsigned-safe.
  function automatic int cnt_width(input int depth);
    return clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/asym_ram_wide_wr.sv
// Wide-write / narrow-read synchronous memory with an enabled, resettable read register.
module asym_ram_wide_wr
  import asym_fifo_pkg::*;
#(
  parameter int RD_WIDTH = 4,
  parameter int RATIO    = 4,
  parameter int WR_DEPTH = 256,
  localparam int LANE_W  = lane_width(RATIO),
  localparam int WR_AW   = clog2(WR_DEPTH),
  localparam int RD_AW   = WR_AW + LANE_W,
  localparam int DEPTH_N = rd_depth(WR_DEPTH, RATIO)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [WR_AW-1:0]          wr_addr,
  input  logic [RD_WIDTH*RATIO-1:0] wr_data,
  input  logic                      rd_en,
  input  logic [RD_AW-1:0]          rd_addr,
  output logic [RD_WIDTH-1:0]       rd_data
);

  logic [RD_WIDTH-1:0] mem [DEPTH_N];
  logic [RD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [RD_AW-1:0]    wr_base;

  always_comb begin
    wr_base   = RD_AW'(wr_addr) << LANE_W;
    rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
  end

  // Storage is never reset; lane i of the wide word lands at {wr_addr, i}.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < RATIO; i++) begin
        mem[wr_base | RD_AW'(i)] <= wr_data[i*RD_WIDTH +: RD_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/asym_stream_fifo.sv
// Width-converting stream FIFO: wide words in, narrow lanes out (lane 0 first), with tlast and flush.
module asym_stream_fifo
  import asym_fifo_pkg::*;
#(
  parameter int RD_WIDTH   = 4,
  parameter int RATIO      = 4,
  parameter int WR_DEPTH   = 256,
  localparam int WR_WIDTH  = wr_width(RD_WIDTH, RATIO),
  localparam int RD_DEPTH  = rd_depth(WR_DEPTH, RATIO),
  localparam int CNT_WIDTH = cnt_width(RD_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WR_WIDTH-1:0]  s_tdata,
  input  logic                 s_tlast,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [RD_WIDTH-1:0]  m_tdata,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [CNT_WIDTH-1:0] count
);

  localparam int LANE_W = lane_width(RATIO);
  localparam int WR_AW  = clog2(WR_DEPTH);
  localparam int RD_AW  = WR_AW + LANE_W;
  localparam logic [RD_AW-1:0]     LANE_MASK = RD_AW'(RATIO - 1);
  localparam logic [CNT_WIDTH-1:0] RATIO_CNT = CNT_WIDTH'(RATIO);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(RD_DEPTH);

  if (!is_pow2(RATIO)) begin : g_bad_ratio
    $error("asym_stream_fifo: RATIO must be a power of two");
  end
  if (!is_pow2(WR_DEPTH) || WR_DEPTH < 2) begin : g_bad_depth
    $error("asym_stream_fifo: WR_DEPTH must be a power of two >= 2");
  end

  logic [WR_AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [RD_AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] mem_count_q, mem_count_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic                 tlast_mem [WR_DEPTH];
  logic                 wr_acc, issue, rd_lane_last;
  logic [WR_AW-1:0]     rd_wide;

  always_comb begin
    s_tready     = !rst && !flush && ((DEPTH_CNT - mem_count_q) >= RATIO_CNT);
    wr_acc       = s_tvalid && s_tready;
    // Issue looks only at registered occupancy, so a slot is never read on the edge it is written.
    issue        = (mem_count_q != '0) && (!m_tvalid_q || m_tready) && !flush;
    rd_wide      = WR_AW'(rd_ptr_q >> LANE_W);
    rd_lane_last = (rd_ptr_q & LANE_MASK) == LANE_MASK;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    m_tvalid_d  = m_tvalid_q;
    m_tlast_d   = m_tlast_q;

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      mem_count_d = '0;
      m_tvalid_d  = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + WR_AW'(1);
      if (issue) begin
        rd_ptr_d   = rd_ptr_q + RD_AW'(1);
        m_tvalid_d = 1'b1;
        m_tlast_d  = tlast_mem[rd_wide] && rd_lane_last;
      end else if (m_tvalid_q && m_tready) begin
        m_tvalid_d = 1'b0;
      end
      mem_count_d = mem_count_q + (wr_acc ? RATIO_CNT : '0) - (issue ? CNT_WIDTH'(1) : '0);
    end

    count = mem_count_q + CNT_WIDTH'(m_tvalid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) tlast_mem[wr_ptr_q] <= s_tlast;
  end

  asym_ram_wide_wr #(
    .RD_WIDTH (RD_WIDTH),
    .RATIO    (RATIO),
    .WR_DEPTH (WR_DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (s_tdata),
    .rd_en   (issue),
    .rd_addr (rd_ptr_q),
    .rd_data (m_tdata)
  );

  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;

endmodule

// File: tb/tb_asym_stream_fifo.sv
// Bench for asym_stream_fifo: queue-level reference model checked every cycle plus directed literal checks.
module tb_asym_stream_fifo;

  localparam int RDW = 4;
  localparam int RAT = 4;
  localparam int WD  = 256;
  localparam int RDD = WD * RAT;
  localparam int CW  = 12;
  localparam int CW1 = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          flush = 0;
  logic [15:0]   s_tdata = '0;
  logic          s_tlast = 0;
  logic          s_tvalid = 0;
  logic          s_tready;
  logic [3:0]    m_tdata;
  logic          m_tlast;
  logic          m_tvalid;
  logic          m_tready = 0;
  logic [CW-1:0] count;

  logic           r1_flush = 0;
  logic [3:0]     r1_tdata = '0;
  logic           r1_tlast = 0;
  logic           r1_tvalid = 0;
  logic           r1_tready;
  logic [3:0]     r1_mdata;
  logic           r1_mlast;
  logic           r1_mvalid;
  logic           r1_mready = 0;
  logic [CW1-1:0] r1_count;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  asym_stream_fifo #(.RD_WIDTH(RDW), .RATIO(RAT), .WR_DEPTH(WD)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .count(count)
  );

  asym_stream_fifo #(.RD_WIDTH(4), .RATIO(1), .WR_DEPTH(4)) dut_r1 (
    .clk(clk), .rst(rst), .flush(r1_flush),
    .s_tdata(r1_tdata), .s_tlast(r1_tlast), .s_tvalid(r1_tvalid), .s_tready(r1_tready),
    .m_tdata(r1_mdata), .m_tlast(r1_mlast), .m_tvalid(r1_mvalid), .m_tready(r1_mready),
    .count(r1_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  // Reference model: narrow entries waiting in memory, plus the presented output word.
  typedef struct packed { logic last; logic [RDW-1:0] data; } ent_t;
  ent_t           mq[$];
  logic           mv = 0;
  logic           ml = 0;
  logic [RDW-1:0] md = '0;

  function automatic logic model_ready();
    return !rst && !flush && ((RDD - mq.size()) >= RAT);
  endfunction

  initial forever begin : model
    bit   iss, acc;
    ent_t e;
    @(posedge clk or posedge rst);
    if (rst) begin
      mq.delete(); mv = 0; md = '0; ml = 0;
    end else begin
      iss = (mq.size() != 0) && (!mv || m_tready) && !flush;
      acc = s_tvalid && model_ready();
      if (flush) begin
        mq.delete(); mv = 0;
      end else begin
        if (iss) begin
          e = mq.pop_front(); md = e.data; ml = e.last; mv = 1;
        end else if (mv && m_tready) begin
          mv = 0;
        end
        if (acc)
          for (int i = 0; i < RAT; i++)
            mq.push_back('{last: s_tlast && (i == RAT - 1), data: s_tdata[i*RDW +: RDW]});
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    chk("m_tvalid", 32'(m_tvalid), 32'(mv));
    chk("count", 32'(count), 32'(mq.size()) + 32'(mv));
    chk("s_tready", 32'(s_tready), 32'(model_ready()));
    if (mv) begin
      chk("m_tdata", 32'(m_tdata), 32'(md));
      chk("m_tlast", 32'(m_tlast), 32'(ml));
    end
  end

  bit seq_en = 0;
  int seq = 0;
  initial forever begin : seq_mon
    @(negedge clk);
    if (seq_en && m_tvalid && m_tready) begin
      chk("stream_seq", 32'(m_tdata), 32'(seq[3:0]));
      seq++;
    end
  end

  logic [4:0] r1_q[$];
  initial forever begin : r1_mon
    @(negedge clk);
    if (r1_mvalid && r1_mready) r1_q.push_back({r1_mlast, r1_mdata});
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input logic [15:0] d, input logic l);
    bit r; int n;
    s_tdata = d; s_tlast = l; s_tvalid = 1; n = 0;
    do begin
      @(negedge clk); r = s_tready;
      @(posedge clk); #2; n++;
    end while (!r && n < 2000);
    chk("push_accepted", 32'(r), 32'(1));
  endtask

  task automatic push1(input logic [3:0] d, input logic l);
    bit r; int n;
    r1_tdata = d; r1_tlast = l; r1_tvalid = 1; n = 0;
    do begin
      @(negedge clk); r = r1_tready;
      @(posedge clk); #2; n++;
    end while (!r && n < 50);
    chk("r1_push_accepted", 32'(r), 32'(1));
  endtask

  initial begin : stim
    logic [15:0] w;
    step(2);
    chk("rst_tdata", 32'(m_tdata), 0);
    chk("rst_tlast", 32'(m_tlast), 0);
    chk("rst_tvalid", 32'(m_tvalid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_tready", 32'(s_tready), 0);
    chk("rst_r1_count", 32'(r1_count), 0);
    rst = 0;
    step();
    chk("post_rst_tready", 32'(s_tready), 1);

    // Basic lane order and tlast placement.
    m_tready = 1;
    push(16'h4321, 1'b1);
    s_tvalid = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("basic_valid", 32'(m_tvalid), 1);
      chk("basic_data", 32'(m_tdata), 32'(k + 1));
      chk("basic_last", 32'(m_tlast), 32'(k == 3));
    end
    step();
    chk("basic_end_valid", 32'(m_tvalid), 0);
    chk("basic_end_count", 32'(count), 0);

    // Backpressure holds the first lane stable.
    m_tready = 0;
    push(16'hA987, 1'b0);
    s_tvalid = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_valid", 32'(m_tvalid), 1);
      chk("bp_data", 32'(m_tdata), 32'h7);
      chk("bp_count", 32'(count), 4);
    end
    chk("bp_model_count", 32'(mq.size()) + 32'(mv), 4);
    m_tready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_release_data", 32'(m_tdata), 32'(8 + k));
    end
    step();
    chk("bp_drained", 32'(m_tvalid), 0);

    // Full boundary.
    m_tready = 0;
    for (int i = 0; i < 256; i++) push(16'(i * 7), i[0]);
    s_tvalid = 0;
    chk("full_tready", 32'(s_tready), 0);
    chk("full_count", 32'(count), 1024);
    chk("full_model_count", 32'(mq.size()) + 32'(mv), 1024);
    m_tready = 1; step(); m_tready = 0;
    chk("full_pop1_count", 32'(count), 1023);
    chk("full_pop1_tready", 32'(s_tready), 0);
    m_tready = 1; step(3); m_tready = 0;
    chk("full_pop4_count", 32'(count), 1020);
    chk("full_pop4_tready", 32'(s_tready), 1);
    m_tready = 1;
    for (int n = 0; n < 1100 && count != 0; n++) step();
    chk("full_drain_count", 32'(count), 0);

    // Concurrent streaming across pointer wrap.
    seq = 0; seq_en = 1;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++) w[i*4 +: 4] = 4'(4 * k + i);
      push(w, k % 5 == 4);
    end
    s_tvalid = 0;
    for (int n = 0; n < 3000 && seq < 2400; n++) step();
    seq_en = 0;
    chk("stream_total", 32'(seq), 2400);

    // Flush mid-stream.
    m_tready = 0;
    push(16'h3210, 1'b0);
    push(16'h7654, 1'b0);
    push(16'hBA98, 1'b1);
    s_tvalid = 0;
    step(2);
    flush = 1; s_tvalid = 1; s_tdata = 16'hEEEE; m_tready = 1;
    #1;
    chk("flush_tready", 32'(s_tready), 0);
    step();
    flush = 0; s_tvalid = 0;
    chk("flush_valid", 32'(m_tvalid), 0);
    chk("flush_count", 32'(count), 0);
    push(16'hFEDC, 1'b0);
    s_tvalid = 0;
    step();
    chk("flush_next_valid", 32'(m_tvalid), 1);
    chk("flush_next_data", 32'(m_tdata), 32'hC);
    step(4);

    // Asynchronous reset between edges.
    m_tready = 0;
    push(16'h1234, 1'b0);
    s_tvalid = 0;
    step();
    chk("arst_pre_valid", 32'(m_tvalid), 1);
    #1 rst = 1;
    #1;
    chk("arst_valid", 32'(m_tvalid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_tready", 32'(s_tready), 0);
    step();
    rst = 0;
    m_tready = 1;
    push(16'h8765, 1'b1);
    s_tvalid = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("arst_data", 32'(m_tdata), 32'(5 + k));
      chk("arst_last", 32'(m_tlast), 32'(k == 3));
    end
    step();

    // RATIO=1 variant of the basic test.
    r1_mready = 1;
    for (int k = 1; k <= 4; k++) push1(4'(k), k == 4);
    r1_tvalid = 0;
    step(4);
    chk("r1_num_out", 32'(r1_q.size()), 4);
    for (int i = 0; i < 4 && i < r1_q.size(); i++) begin
      chk("r1_data", 32'(r1_q[i][3:0]), 32'(i + 1));
      chk("r1_last", 32'(r1_q[i][4]), 32'(i == 3));
    end
    chk("r1_end_count", 32'(r1_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
